// File: rtl/ghyston_mem_pkg.sv
// Shared memory-subsystem definitions: default bus widths, starvation limit and port identifiers.
package ghyston_mem_pkg;

    localparam int unsigned ADDR_W       = 13;
    localparam int unsigned DATA_W       = 32;
    localparam int unsigned STARVE_LIMIT = 4;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_LS = 1'b1
    } port_e;

    // Bits needed to hold 0..limit inclusive.
    function automatic int unsigned ctr_width(input int unsigned limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/mem_starve_ctr.sv
// Saturating starvation counter; sat flags that the count has reached LIMIT.
module mem_starve_ctr #(
    parameter int unsigned LIMIT = ghyston_mem_pkg::STARVE_LIMIT
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic sat
);
    import ghyston_mem_pkg::*;

    localparam int unsigned   CW  = ctr_width(LIMIT);
    localparam logic [CW-1:0] LIM = CW'(LIMIT);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != LIM)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign sat = (cnt == LIM);

endmodule

// File: rtl/ram_arbiter.sv
// Two-port single-RAM arbiter: load/store has priority, fetch is forced through after
// STARVE_LIMIT consecutive denials. Read data returns one cycle after the accept.
module ram_arbiter #(
    parameter int unsigned ADDR_W       = ghyston_mem_pkg::ADDR_W,
    parameter int unsigned DATA_W       = ghyston_mem_pkg::DATA_W,
    parameter int unsigned STARVE_LIMIT = ghyston_mem_pkg::STARVE_LIMIT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_rnw,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_ack,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_rnw,
    output logic              ram_cs_b,
    input  logic [DATA_W-1:0] ram_dout
);
    import ghyston_mem_pkg::port_e;
    import ghyston_mem_pkg::PORT_IF;
    import ghyston_mem_pkg::PORT_LS;

    logic  starve_sat;
    logic  starve_inc;
    logic  if_rv_q;
    logic  ls_rv_q;
    port_e rd_owner;

    always_comb begin
        if_ack = 1'b0;
        ls_ack = 1'b0;
        if (!reset) begin
            if (ls_req && !(if_req && starve_sat)) begin
                ls_ack = 1'b1;
            end else if (if_req) begin
                if_ack = 1'b1;
            end
        end
    end

    assign starve_inc = if_req && !if_ack;

    mem_starve_ctr #(
        .LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk  (clk),
        .reset(reset),
        .inc  (starve_inc),
        .clr  (!starve_inc),
        .sat  (starve_sat)
    );

    // With no grant the RAM lines follow the ls_* inputs, so they only move when the requester moves.
    assign ram_cs_b = !(if_ack || ls_ack);
    assign ram_addr = if_ack ? if_addr : ls_addr;
    assign ram_rnw  = if_ack ? 1'b1    : ls_rnw;
    assign ram_din  = ls_wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            if_rv_q  <= 1'b0;
            ls_rv_q  <= 1'b0;
            rd_owner <= PORT_IF;
        end else begin
            if_rv_q <= if_ack;
            ls_rv_q <= ls_ack && ls_rnw;
            if (if_ack) begin
                rd_owner <= PORT_IF;
            end else if (ls_ack && ls_rnw) begin
                rd_owner <= PORT_LS;
            end
        end
    end

    // A read accepted just before reset would otherwise surface during the reset cycle.
    assign if_rvalid = if_rv_q && !reset;
    assign ls_rvalid = ls_rv_q && !reset;
    assign if_rdata  = (rd_owner == PORT_IF) ? ram_dout : '0;
    assign ls_rdata  = (rd_owner == PORT_LS) ? ram_dout : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural synchronous RAM attached.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [12:0] if_addr;
    logic        if_ack;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req;
    logic        ls_rnw;
    logic [12:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_ack;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;
    logic [12:0] ram_addr;
    logic [31:0] ram_din;
    logic        ram_rnw;
    logic        ram_cs_b;
    logic [31:0] ram_dout;

    logic [31:0] mem [0:8191];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ram_arbiter #(
        .ADDR_W      (13),
        .DATA_W      (32),
        .STARVE_LIMIT(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_ack   (if_ack),
        .if_rvalid(if_rvalid),
        .if_rdata (if_rdata),
        .ls_req   (ls_req),
        .ls_rnw   (ls_rnw),
        .ls_addr  (ls_addr),
        .ls_wdata (ls_wdata),
        .ls_ack   (ls_ack),
        .ls_rvalid(ls_rvalid),
        .ls_rdata (ls_rdata),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_rnw  (ram_rnw),
        .ram_cs_b (ram_cs_b),
        .ram_dout (ram_dout)
    );

    always @(posedge clk) begin
        if (!ram_cs_b) begin
            if (ram_rnw) ram_dout <= mem[ram_addr];
            else         mem[ram_addr] <= ram_din;
        end
    end

    typedef struct {
        logic        if_req;
        logic [12:0] if_addr;
        logic        ls_req;
        logic        ls_rnw;
        logic [12:0] ls_addr;
        logic [31:0] ls_wdata;
        logic        e_if_ack;
        logic        e_ls_ack;
        logic        e_cs_b;
        logic        e_rnw;
        logic [12:0] e_addr;
        logic        e_if_rv;
        logic        e_ls_rv;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic ir, input logic [12:0] ia, input logic lr,
                         input logic rnw, input logic [12:0] la, input logic [31:0] wd);
        if_req   = ir;
        if_addr  = ia;
        ls_req   = lr;
        ls_rnw   = rnw;
        ls_addr  = la;
        ls_wdata = wd;
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 32'h1000_0000 + i;
        mem[13'h0010] = 32'hDEADBEEF;

        //           if_req if_addr   ls ls_rnw ls_addr   ls_wdata      ifa lsa csb rnw addr     ifrv lsrv rdata
        vecs[0]  = '{1'b0, 13'h0000, 1'b0, 1'b1, 13'h0000, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 13'h0000, 1'b0, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 13'h0010, 1'b0, 1'b1, 13'h0000, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 13'h0010, 1'b1, 1'b0, 32'hDEADBEEF};
        vecs[2]  = '{1'b0, 13'h0000, 1'b1, 1'b1, 13'h0020, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 13'h0020, 1'b0, 1'b1, 32'h10000020};
        vecs[3]  = '{1'b0, 13'h0000, 1'b1, 1'b0, 13'h0030, 32'hCAFEF00D, 1'b0, 1'b1, 1'b0, 1'b0, 13'h0030, 1'b0, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 13'h0000, 1'b1, 1'b1, 13'h0030, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 13'h0030, 1'b0, 1'b1, 32'hCAFEF00D};
        vecs[5]  = '{1'b1, 13'h0050, 1'b1, 1'b1, 13'h0040, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 13'h0040, 1'b0, 1'b1, 32'h10000040};
        vecs[6]  = '{1'b1, 13'h0050, 1'b0, 1'b1, 13'h0040, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 13'h0050, 1'b1, 1'b0, 32'h10000050};
        vecs[7]  = '{1'b1, 13'h0070, 1'b1, 1'b0, 13'h0060, 32'h11112222, 1'b0, 1'b1, 1'b0, 1'b0, 13'h0060, 1'b0, 1'b0, 32'h0};
        vecs[8]  = '{1'b0, 13'h0070, 1'b0, 1'b0, 13'h0060, 32'h11112222, 1'b0, 1'b0, 1'b1, 1'b0, 13'h0060, 1'b0, 1'b0, 32'h0};
        vecs[9]  = '{1'b0, 13'h0000, 1'b1, 1'b1, 13'h0060, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 13'h0060, 1'b0, 1'b1, 32'h11112222};
        vecs[10] = '{1'b1, 13'h1FFF, 1'b0, 1'b1, 13'h0000, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 13'h1FFF, 1'b1, 1'b0, 32'h10001FFF};

        // Reset with both requests pending: nothing may be granted.
        reset = 1'b1;
        drive(1'b1, 13'h0010, 1'b1, 1'b0, 13'h0020, 32'hFFFF_FFFF);
        @(negedge clk); #1;
        chk("rst_if_ack", if_ack, 1'b0);
        chk("rst_ls_ack", ls_ack, 1'b0);
        chk("rst_cs_b", ram_cs_b, 1'b1);
        @(posedge clk); #1;
        chk("rst_if_rv", if_rvalid, 1'b0);
        chk("rst_ls_rv", ls_rvalid, 1'b0);
        chk("rst_starve", dut.u_starve.cnt, 0);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 13'h0, 1'b0, 1'b1, 13'h0, 32'h0);

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            drive(vecs[i].if_req, vecs[i].if_addr, vecs[i].ls_req,
                  vecs[i].ls_rnw, vecs[i].ls_addr, vecs[i].ls_wdata);
            #1;
            chk($sformatf("v%0d_if_ack", i), if_ack, vecs[i].e_if_ack);
            chk($sformatf("v%0d_ls_ack", i), ls_ack, vecs[i].e_ls_ack);
            chk($sformatf("v%0d_cs_b", i), ram_cs_b, vecs[i].e_cs_b);
            chk($sformatf("v%0d_rnw", i), ram_rnw, vecs[i].e_rnw);
            chk($sformatf("v%0d_addr", i), ram_addr, vecs[i].e_addr);
            if (vecs[i].e_ls_ack && !vecs[i].e_rnw)
                chk($sformatf("v%0d_din", i), ram_din, vecs[i].ls_wdata);
            @(posedge clk); #1;
            chk($sformatf("v%0d_if_rv", i), if_rvalid, vecs[i].e_if_rv);
            chk($sformatf("v%0d_ls_rv", i), ls_rvalid, vecs[i].e_ls_rv);
            if (vecs[i].e_if_rv) chk($sformatf("v%0d_if_rdata", i), if_rdata, vecs[i].e_rdata);
            if (vecs[i].e_ls_rv) chk($sformatf("v%0d_ls_rdata", i), ls_rdata, vecs[i].e_rdata);
        end

        // Store then load at the top address, back to back.
        @(negedge clk);
        drive(1'b0, 13'h0, 1'b1, 1'b0, 13'h1FFF, 32'hA5A5A5A5);
        #1;
        chk("sl_wr_ack", ls_ack, 1'b1);
        @(negedge clk);
        drive(1'b0, 13'h0, 1'b1, 1'b1, 13'h1FFF, 32'h0);
        #1;
        chk("sl_rd_ack", ls_ack, 1'b1);
        chk("sl_rd_addr", ram_addr, 13'h1FFF);
        @(posedge clk); #1;
        chk("sl_ls_rv", ls_rvalid, 1'b1);
        chk("sl_ls_rdata", ls_rdata, 32'hA5A5A5A5);

        // Continuous contention: fetch wins every fifth cycle.
        @(negedge clk);
        drive(1'b1, 13'h0100, 1'b1, 1'b1, 13'h0200, 32'h0);
        for (int k = 0; k < 15; k++) begin
            #1;
            chk($sformatf("ct%0d_if_ack", k), if_ack, (k % 5) == 4);
            chk($sformatf("ct%0d_ls_ack", k), ls_ack, (k % 5) != 4);
            @(posedge clk); #1;
            chk($sformatf("ct%0d_if_rv", k), if_rvalid, (k % 5) == 4);
            chk($sformatf("ct%0d_ls_rv", k), ls_rvalid, (k % 5) != 4);
            if ((k % 5) == 4) chk($sformatf("ct%0d_if_rdata", k), if_rdata, 32'h10000100);
            else              chk($sformatf("ct%0d_ls_rdata", k), ls_rdata, 32'h10000200);
            @(negedge clk);
        end

        // Alternate fetch and load reads every cycle.
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) drive(1'b1, 13'h0300 + 13'(k), 1'b0, 1'b1, 13'h0, 32'h0);
            else            drive(1'b0, 13'h0, 1'b1, 1'b1, 13'h0400 + 13'(k), 32'h0);
            #1;
            chk($sformatf("il%0d_ack", k), {if_ack, ls_ack}, (k % 2 == 0) ? 2'b10 : 2'b01);
            @(posedge clk); #1;
            chk($sformatf("il%0d_rv", k), {if_rvalid, ls_rvalid}, (k % 2 == 0) ? 2'b10 : 2'b01);
            if (k % 2 == 0) chk($sformatf("il%0d_if_rdata", k), if_rdata, 32'h10000300 + k);
            else            chk($sformatf("il%0d_ls_rdata", k), ls_rdata, 32'h10000400 + k);
            @(negedge clk);
        end

        // Load accepted, then reset in the following cycle; a store is held during reset.
        drive(1'b1, 13'h0500, 1'b1, 1'b1, 13'h0600, 32'h0);
        #1;
        chk("rm_ls_ack", ls_ack, 1'b1);
        @(posedge clk); #1;
        reset = 1'b1;
        drive(1'b1, 13'h0500, 1'b1, 1'b0, 13'h0700, 32'hFFFFFFFF);
        #1;
        chk("rm_ls_rv_in_rst", ls_rvalid, 1'b0);
        chk("rm_if_rv_in_rst", if_rvalid, 1'b0);
        chk("rm_acks", {if_ack, ls_ack}, 2'b00);
        chk("rm_cs_b", ram_cs_b, 1'b1);
        @(posedge clk); #1;
        chk("rm_ls_rv_after", ls_rvalid, 1'b0);
        chk("rm_starve", dut.u_starve.cnt, 0);
        chk("rm_cs_b2", ram_cs_b, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 13'h0, 1'b0, 1'b1, 13'h0, 32'h0);

        // Idle for 10 cycles.
        for (int k = 0; k < 10; k++) begin
            #1;
            chk($sformatf("id%0d_cs_b", k), ram_cs_b, 1'b1);
            chk($sformatf("id%0d_acks", k), {if_ack, ls_ack}, 2'b00);
            @(posedge clk); #1;
            chk($sformatf("id%0d_rv", k), {if_rvalid, ls_rvalid}, 2'b00);
            @(negedge clk);
        end

        // The store held during reset must not have reached the RAM.
        drive(1'b0, 13'h0, 1'b1, 1'b1, 13'h0700, 32'h0);
        #1;
        chk("nw_ack", ls_ack, 1'b1);
        @(posedge clk); #1;
        chk("nw_ls_rv", ls_rvalid, 1'b1);
        chk("nw_ls_rdata", ls_rdata, 32'h10000700);
        @(negedge clk);
        drive(1'b0, 13'h0, 1'b0, 1'b1, 13'h0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- ADDR_W, 13, RAM word-address width.
- DATA_W, 32, data width.
- STARVE_LIMIT, 4, consecutive fetch denials before fetch is forced to win.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state updates on the rising edge.
- reset, in, 1, synchronous, active-high reset.
- if_req, in, 1, fetch read request.
- if_addr, in, ADDR_W, fetch word address.
- if_ack, out, 1, fetch request accepted this cycle.
- if_rvalid, out, 1, fetch read data valid.
- if_rdata, out, DATA_W, fetch read data.
- ls_req, in, 1, load/store request.
- ls_rnw, in, 1, load/store direction: 1 = read, 0 = write.
- ls_addr, in, ADDR_W, load/store word address.
- ls_wdata, in, DATA_W, store data.
- ls_ack, out, 1, load/store request accepted this cycle.
- ls_rvalid, out, 1, load data valid.
- ls_rdata, out, DATA_W, load data.
- ram_addr, out, ADDR_W, RAM address.
- ram_din, out, DATA_W, RAM write data.
- ram_rnw, out, 1, RAM direction: 1 = read.
- ram_cs_b, out, 1, RAM chip select, active-low.
- ram_dout, in, DATA_W, RAM read data, valid one cycle after the read edge.

Function
REQ-003 Grant SHALL be combinational from the current requests and starve count; at most one of if_ack and ls_ack SHALL be high in any cycle.
REQ-004 Only if_req high: the fetch port SHALL be granted.
REQ-005 Only ls_req high: the load/store port SHALL be granted.
REQ-006 Both requests high: load/store SHALL win unless starve_cnt == STARVE_LIMIT, in which case fetch SHALL win.
REQ-007 starve_cnt SHALL increment, saturating at STARVE_LIMIT, in each cycle if_req is high and fetch is not granted; it SHALL clear when fetch is granted or if_req is low.
REQ-008 In a granted cycle: ram_cs_b = 0, and ram_addr, ram_rnw, ram_din SHALL come from the winner; fetch SHALL always drive ram_rnw = 1.
REQ-009 No grant: ram_cs_b = 1; ram_addr, ram_din and ram_rnw SHALL be don't-care but stable (hold the ls_* values).
REQ-010 An accepted read in cycle N SHALL assert the owner's rvalid for exactly cycle N+1.
REQ-011 rdata SHALL equal ram_dout during rvalid; rdata is undefined otherwise.
REQ-012 An accepted write SHALL produce no rvalid; the RAM commits it at the end of the accept cycle.
REQ-013 Back-to-back accepts SHALL be supported, with no bubble between them on the same port or across ports.
REQ-014 Read after write to the same address in consecutive cycles SHALL return the new data.
REQ-015 A requester SHALL hold req, addr, rnw and wdata stable until acked; the arbiter SHALL NOT buffer requests.

Reset
REQ-016 While reset is high, both ack outputs SHALL be 0, ram_cs_b SHALL be 1, and no RAM access SHALL be issued.
REQ-017 On the first edge with reset high: starve_cnt = 0, if_rvalid = 0, ls_rvalid = 0, and the read-owner register SHALL be cleared.
REQ-018 A read accepted in the cycle before reset asserts SHALL NOT produce rvalid in the reset cycle.

Structure
REQ-019 ADDR_W, DATA_W and a port-id enum (PORT_IF, PORT_LS) SHALL live in the shared package ghyston_mem_pkg.
REQ-020 The saturating starvation counter SHALL be the single sub-module, mem_starve_ctr, with parameter LIMIT and ports clk, reset, inc, clr, sat.
REQ-021 The state SHALL be limited to starve_cnt, the read-owner register and the two rvalid registers; all other logic SHALL be combinational.

Verification
REQ-022 Fetch alone: if_req = 1, if_addr = 0x0010, RAM[0x10] = 0xDEADBEEF -> if_ack in cycle N; if_rvalid with if_rdata = 0xDEADBEEF in cycle N+1.
REQ-023 Store then load: ls write to 0x1FFF with 0xA5A5A5A5, then ls read of 0x1FFF in the next cycle -> ls_rdata = 0xA5A5A5A5 one cycle after the read ack.
REQ-024 Contention: both ports request continuously -> ls_ack for 4 cycles, if_ack on the 5th, then ls wins again; pattern repeats with period 5.
REQ-025 Interleave: alternate if and ls reads every cycle -> each rvalid goes to the correct port, with no cross-delivery of data.
REQ-026 Reset mid-read: ls read acked in cycle N, reset high in cycle N+1 -> ls_rvalid = 0, ram_cs_b = 1, and starve_cnt = 0 after the edge.
REQ-027 Idle: no requests for 10 cycles -> ram_cs_b = 1 throughout; no ack and no rvalid.
